rifl_decode: RTL and testbench



---
 rtl/rifl_pkg.sv | 18 +
 rtl/rifl_sync_fifo_fwft.sv | 47 ++++
 rtl/rifl_decode.sv | 116 +++++++++++
 tb/tb_rifl_decode.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/rifl_pkg.sv
// Shared RIFL definitions: frame tags, pause FSM states and byte-count width.
package rifl_pkg;

   typedef enum logic [1:0] {
      TAG_IDLE      = 2'b00,
      TAG_DATA      = 2'b01,
      TAG_LAST_FULL = 2'b10,
      TAG_LAST_PART = 2'b11
   } rifl_tag_e;

   typedef enum logic {
      PS_RUN   = 1'b0,
      PS_PAUSE = 1'b1
   } pause_state_e;

   localparam int BYTE_CNT_WIDTH = 8;

endpackage

// File: rtl/rifl_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; read data is zero while empty.
module rifl_sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   output logic                     full,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             wr_fire;
   logic             rd_fire;

   // Extra wrap bit distinguishes full from empty when the index bits match.
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign count   = wr_ptr - rd_ptr;
   assign wr_fire = wr_en && !full;
   assign rd_fire = rd_en && !empty;
   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_ptr[AW-1:0]] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
         if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/rifl_decode.sv
// RIFL rx decode: tag decode into a FWFT buffer feeding the user AXI-stream lane,
// with hysteretic pause_req and a sticky overflow flag.
module rifl_decode
   import rifl_pkg::*;
#(
   parameter int PAYLOAD_WIDTH = 240,
   parameter int FIFO_DEPTH    = 64,
   parameter int PAUSE_ON      = 48,
   parameter int PAUSE_OFF     = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [PAYLOAD_WIDTH+1:0]        rifl_rx_payload,
   input  logic                            rifl_rx_valid,
   output logic [PAYLOAD_WIDTH-1:0]        rx_lane_tdata,
   output logic [BYTE_CNT_WIDTH-1:0]       rx_lane_byte_cnt,
   output logic                            rx_lane_tlast,
   output logic                            rx_lane_tvalid,
   input  logic                            rx_lane_tready,
   output logic                            pause_req,
   output logic                            overflow,
   output logic [$clog2(FIFO_DEPTH):0]     occupancy
);

   localparam int OW = $clog2(FIFO_DEPTH) + 1;

   typedef struct packed {
      logic                      tlast;
      logic [BYTE_CNT_WIDTH-1:0] byte_cnt;
      logic [PAYLOAD_WIDTH-1:0]  tdata;
   } entry_t;

   rifl_tag_e    tag;
   entry_t       wr_entry;
   entry_t       rd_entry;
   logic         full;
   logic         empty;
   logic         frame_in;
   logic         wr_fire;
   logic         rd_fire;
   logic [OW-1:0] occ_nxt;
   pause_state_e state;

   assign tag      = rifl_tag_e'(rifl_rx_payload[PAYLOAD_WIDTH+1:PAYLOAD_WIDTH]);
   assign frame_in = rifl_rx_valid && (tag != TAG_IDLE);
   assign wr_fire  = frame_in && !full;
   assign rd_fire  = rx_lane_tvalid && rx_lane_tready;

   // LAST_PART carries its byte count in the top payload byte; it is not clamped.
   always_comb begin
      wr_entry          = '0;
      wr_entry.tdata    = rifl_rx_payload[PAYLOAD_WIDTH-1:0];
      wr_entry.byte_cnt = BYTE_CNT_WIDTH'(PAYLOAD_WIDTH / 8);
      wr_entry.tlast    = 1'b0;
      case (tag)
         TAG_LAST_FULL: wr_entry.tlast = 1'b1;
         TAG_LAST_PART: begin
            wr_entry.tlast    = 1'b1;
            wr_entry.byte_cnt = rifl_rx_payload[PAYLOAD_WIDTH-1 -: BYTE_CNT_WIDTH];
            wr_entry.tdata[PAYLOAD_WIDTH-1 -: BYTE_CNT_WIDTH] = '0;
         end
         default: ;
      endcase
   end

   rifl_sync_fifo_fwft #(
      .WIDTH ($bits(entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_fire),
      .wr_data (wr_entry),
      .full    (full),
      .rd_en   (rd_fire),
      .rd_data (rd_entry),
      .empty   (empty),
      .count   (occupancy)
   );

   assign rx_lane_tvalid   = !empty;
   assign rx_lane_tdata    = rd_entry.tdata;
   assign rx_lane_byte_cnt = rd_entry.byte_cnt;
   assign rx_lane_tlast    = rd_entry.tlast;

   assign occ_nxt = occupancy + OW'(wr_fire) - OW'(rd_fire);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= PS_RUN;
         pause_req <= 1'b0;
      end else begin
         case (state)
            PS_RUN: if (occ_nxt >= OW'(PAUSE_ON)) begin
               state     <= PS_PAUSE;
               pause_req <= 1'b1;
            end
            PS_PAUSE: if (occ_nxt <= OW'(PAUSE_OFF)) begin
               state     <= PS_RUN;
               pause_req <= 1'b0;
            end
            default: begin
               state     <= PS_RUN;
               pause_req <= 1'b0;
            end
         endcase
      end
   end

   // A frame arriving on a full buffer is lost even if a read frees a slot this cycle.
   always_ff @(posedge clk) begin
      if (rst)                   overflow <= 1'b0;
      else if (frame_in && full) overflow <= 1'b1;
   end

endmodule

// File: tb/tb_rifl_decode.sv
// Scoreboarded bench for rifl_decode: directed frames in, lane beats checked by a monitor.
module tb_rifl_decode;

   localparam int PW = 240;
   localparam int DEPTH = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [PW+1:0] rifl_rx_payload = '0;
   logic          rifl_rx_valid = 1'b0;
   logic [PW-1:0] rx_lane_tdata;
   logic [7:0]    rx_lane_byte_cnt;
   logic          rx_lane_tlast;
   logic          rx_lane_tvalid;
   logic          rx_lane_tready = 1'b0;
   logic          pause_req;
   logic          overflow;
   logic [6:0]    occupancy;

   typedef struct {
      logic [PW-1:0] d;
      logic [7:0]    bc;
      logic          last;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   rifl_decode #(.PAYLOAD_WIDTH(PW), .FIFO_DEPTH(DEPTH), .PAUSE_ON(48), .PAUSE_OFF(16)) dut (
      .clk              (clk),
      .rst              (rst),
      .rifl_rx_payload  (rifl_rx_payload),
      .rifl_rx_valid    (rifl_rx_valid),
      .rx_lane_tdata    (rx_lane_tdata),
      .rx_lane_byte_cnt (rx_lane_byte_cnt),
      .rx_lane_tlast    (rx_lane_tlast),
      .rx_lane_tvalid   (rx_lane_tvalid),
      .rx_lane_tready   (rx_lane_tready),
      .pause_req        (pause_req),
      .overflow         (overflow),
      .occupancy        (occupancy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [PW-1:0] pat(input int id);
      logic [15:0] h;
      h = 16'(id) ^ 16'h5A00;
      return {15{h}};
   endfunction

   // Drive one frame for one cycle; push its expected beat when it should be accepted.
   task automatic send(input logic [1:0] tag, input logic [PW-1:0] d, input bit push);
      exp_t e;
      rifl_rx_payload = {tag, d};
      rifl_rx_valid   = 1'b1;
      if (push) begin
         e.d = d; e.bc = 8'd30; e.last = 1'b0;
         if (tag == 2'b10) e.last = 1'b1;
         if (tag == 2'b11) begin
            e.last = 1'b1;
            e.bc   = d[PW-1 -: 8];
            e.d[PW-1 -: 8] = 8'h00;
         end
         q.push_back(e);
      end
      tick();
      rifl_rx_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name, input int budget);
      int n;
      n = 0;
      while ((q.size() != 0 || rx_lane_tvalid) && n < budget) begin
         tick();
         n++;
      end
      chk({name, "_drain_timeout"}, 32'(n < budget), 32'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rx_lane_tready = 1'b0;
      rifl_rx_valid = 1'b0;
      tick();
      tick();
      q.delete();
      rst = 1'b0;
   endtask

   // Monitor: every handshake must match the oldest expected beat.
   always @(negedge clk) begin
      if (!rst && rx_lane_tvalid && rx_lane_tready) begin
         n_chk++;
         if (q.size() == 0) begin
            $display("FAIL beat_extra: got unexpected beat byte_cnt=%0d tlast=%0b", rx_lane_byte_cnt, rx_lane_tlast);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (rx_lane_tdata === e.d && rx_lane_byte_cnt === e.bc && rx_lane_tlast === e.last) n_pass++;
            else $display("FAIL beat: got bc=%0d last=%0b d=%h expected bc=%0d last=%0b d=%h",
                          rx_lane_byte_cnt, rx_lane_tlast, rx_lane_tdata, e.bc, e.last, e.d);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [PW-1:0] d;
      do_reset();
      chk("rst_tvalid",   32'(rx_lane_tvalid), 32'd0);
      chk("rst_tlast",    32'(rx_lane_tlast), 32'd0);
      chk("rst_byte_cnt", 32'(rx_lane_byte_cnt), 32'd0);
      chk("rst_tdata",    32'(|rx_lane_tdata), 32'd0);
      chk("rst_pause",    32'(pause_req), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_occ",      32'(occupancy), 32'd0);

      // Packet of three DATA beats and a 5-byte LAST_PART.
      rx_lane_tready = 1'b1;
      send(2'b01, pat(1), 1'b1);
      chk("latency_tvalid", 32'(rx_lane_tvalid), 32'd1);
      send(2'b01, pat(2), 1'b1);
      send(2'b01, pat(3), 1'b1);
      d = pat(4);
      d[PW-1 -: 8] = 8'd5;
      send(2'b11, d, 1'b1);
      wait_drain("pkt", 20);

      // IDLE tags interleaved with DATA while stalled.
      rx_lane_tready = 1'b0;
      send(2'b01, pat(10), 1'b1);
      send(2'b00, pat(11), 1'b0);
      chk("idle_occ1", 32'(occupancy), 32'd1);
      send(2'b01, pat(12), 1'b1);
      send(2'b00, pat(13), 1'b0);
      send(2'b00, pat(14), 1'b0);
      chk("idle_occ2", 32'(occupancy), 32'd2);
      send(2'b10, pat(15), 1'b1);
      chk("idle_occ3", 32'(occupancy), 32'd3);
      rx_lane_tready = 1'b1;
      wait_drain("idle", 20);

      // Pause hysteresis: 48 stalled writes, then drain.
      rx_lane_tready = 1'b0;
      for (int i = 0; i < 47; i++) send(2'b01, pat(100 + i), 1'b1);
      chk("pause_47", 32'(pause_req), 32'd0);
      send(2'b01, pat(147), 1'b1);
      chk("pause_48", 32'(pause_req), 32'd1);
      chk("occ_48", 32'(occupancy), 32'd48);
      rx_lane_tready = 1'b1;
      for (int i = 1; i <= 33; i++) begin
         tick();
         chk("drain_occ", 32'(occupancy), 32'(48 - i));
         chk("drain_pause", 32'(pause_req), 32'((48 - i) > 16));
      end
      wait_drain("pause", 40);

      // Full FIFO with a simultaneous read and write: write lost, one beat read.
      rx_lane_tready = 1'b0;
      for (int i = 0; i < 64; i++) send(2'b01, pat(200 + i), 1'b1);
      chk("full_occ", 32'(occupancy), 32'd64);
      chk("full_ovf0", 32'(overflow), 32'd0);
      rx_lane_tready = 1'b1;
      send(2'b01, pat(999), 1'b0);
      chk("full_rw_occ", 32'(occupancy), 32'd63);
      chk("full_rw_ovf", 32'(overflow), 32'd1);
      wait_drain("full_rw", 80);

      // 70 stalled writes: last six dropped, 64 in-order beats.
      do_reset();
      for (int i = 0; i < 70; i++) begin
         send(2'b01, pat(300 + i), i < 64);
         if (i == 63) chk("ovf_at64", 32'(overflow), 32'd0);
         if (i == 64) chk("ovf_at65", 32'(overflow), 32'd1);
      end
      chk("ovf_occ", 32'(occupancy), 32'd64);
      rx_lane_tready = 1'b1;
      wait_drain("ovf", 80);
      chk("ovf_sticky", 32'(overflow), 32'd1);
      chk("ovf_pause_off", 32'(pause_req), 32'd0);

      // Reset with frames buffered and a beat stalled.
      rx_lane_tready = 1'b0;
      for (int i = 0; i < 10; i++) send(2'b01, pat(400 + i), 1'b1);
      chk("pre_rst_occ", 32'(occupancy), 32'd10);
      rst = 1'b1;
      tick();
      chk("mid_rst_tvalid", 32'(rx_lane_tvalid), 32'd0);
      chk("mid_rst_occ", 32'(occupancy), 32'd0);
      chk("mid_rst_pause", 32'(pause_req), 32'd0);
      chk("mid_rst_ovf", 32'(overflow), 32'd0);
      q.delete();
      rst = 1'b0;
      rx_lane_tready = 1'b1;
      tick();
      tick();
      chk("post_rst_tvalid", 32'(rx_lane_tvalid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
